demux_rr_dispatcher: RTL and testbench
======================================

Name: demux_rr_dispatcher

Overview:
- Sequencer for the 4-way N-bit demux datapath: takes one valid/ready input stream and dispatches each word to one of four destination lanes in round-robin order.
- Skips lanes that are masked off; steers data with a one-hot valid per lane.
- Re-targets a word whose destination stalls past a timeout.
- Sits between a single producer (e.g. hex digit source) and four consumers (e.g. per-digit seven-segment registers).

Parameters:
- N, 8, data width in bits.
- TIMEOUT, 16, stall cycles before re-targeting; 0 disables timeout.
- TO_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  word to dispatch.
- in_valid  input  1  in_data valid.
- in_ready  output  1  dispatcher can accept a word this cycle.
- en_mask  input  4  lane enables; bit0=a, bit1=b, bit2=c, bit3=d.
- out_ready  input  4  per-lane consumer ready.
- out_valid  output  4  one-hot lane valid, or zero.
- sel  output  2  current target lane; 0=a, 1=b, 2=c, 3=d.
- out_a, out_b, out_c, out_d  output  N each  lane data; non-selected lanes drive 0.
- timeout_pulse  output  1  one-cycle pulse on each re-target.

Behaviour:
- Reset (async assert, sync release): state IDLE; hold register=0; sel=0; last_lane=3, so the first grant goes to lane 0; out_valid=0; all out_* =0; timeout counter=0; timeout_pulse=0; in_ready=0 while rst_n low.
- States: IDLE (no word held) and SEND (word held, presenting to lane sel).
- any_en = |en_mask.
- in_ready = any_en && (IDLE || (SEND && out_ready[sel])). This is combinational on en_mask and out_ready and gives 1 word/cycle throughput.
- Accept happens when in_valid && in_ready:
  - hold in_data;
  - sel <= next enabled lane after last_lane, searching last_lane+1, +2, +3, +4 mod 4;
  - state <= SEND; counter <= 0.
- Latency: word accepted in cycle k appears on out_* with out_valid[sel]=1 in cycle k+1.
- In SEND:
  - out_valid = 1<<sel.
  - The selected out_* bus = held data; the other three buses = 0 (demux semantics).
  - All outputs come from registers or from the registered state/sel.
- Transfer occurs when out_ready[sel] is high in SEND:
  - last_lane <= sel.
  - If a new word is accepted in the same cycle, stay in SEND with the new data and new sel, chosen after the old sel.
  - Otherwise go to IDLE and out_valid=0 next cycle.
- en_mask change during SEND: the committed lane is kept even if it is now masked. It is released only by transfer or timeout. New grants use the current en_mask.
- Timeout (TIMEOUT>0):
  - Counter increments each SEND cycle without a transfer.
  - When counter == TIMEOUT-1 and there is no transfer: sel <= next enabled lane after the current sel, excluding the current sel; counter <= 0; timeout_pulse=1 for that cycle; the word is kept, not dropped.
  - If no other lane is enabled: sel is unchanged, counter restarts, and timeout_pulse still fires.
- TIMEOUT=0: the counter is held at 0 and the word waits indefinitely.
- Transfer takes priority over timeout in the same cycle.
- en_mask=0 in IDLE: in_ready=0 and the block idles. A held word in SEND still completes.
- out_ready on non-selected lanes is ignored.
- in_valid without in_ready: no state change. The producer must hold in_data stable.
- Reset mid-SEND: the held word is discarded and all outputs clear immediately.

Test Plan:
- Reset then en_mask=4'hF, ready=4'hF; stream 0x11,0x22,0x33,0x44,0x55 back-to-back -> 1 word/cycle; lanes a,b,c,d,a; out_valid 0001,0010,0100,1000,0001; non-selected buses 0; first valid one cycle after first accept.
- en_mask=4'b1010, ready all; send 3 words -> lanes b,d,b; sel 1,3,1; lanes a and c never valid.
- TIMEOUT=4, en_mask=4'hF, out_ready=4'b1110; send 0xA5 -> targets a; after 4 stalled cycles timeout_pulse=1, sel=1; next cycle 0xA5 transfers on out_b.
- en_mask=4'b0001, out_ready=0, TIMEOUT=4 -> timeout_pulse every 4 cycles, sel stays 0, in_ready=0; raising out_ready[0] transfers the word.
- en_mask=0 with in_valid=1 -> in_ready=0 and out_valid=0 indefinitely. Set en_mask=4'b0100 -> accept; word appears on out_c.
- Assert rst_n=0 mid-SEND with out_ready low -> out_valid and all buses 0 immediately. After release the next word goes to lane a.

Source files
------------

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: takes one valid/ready stream and hands each word to
// one of four lanes in round-robin order. Masked lanes are skipped. A word
// whose lane stalls for TIMEOUT cycles is moved to the next enabled lane.
module demux_rr_dispatcher #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   en_mask,
  input  logic [3:0]   out_ready,
  output logic [3:0]   out_valid,
  output logic [1:0]   sel,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic [N-1:0] out_c,
  output logic [N-1:0] out_d,
  output logic         timeout_pulse
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_n;
  logic [N-1:0]    hold, hold_n;
  logic [1:0]      sel_n, last_lane, last_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic            pulse, pulse_n;
  logic            any_en, xfer, accept, timed_out;

  // First enabled lane after base, searching base+1 onward. With wrap set
  // the search may come back to base itself; otherwise base is excluded and
  // is returned unchanged when no other lane qualifies.
  function automatic logic [1:0] next_lane(input logic [1:0] base,
                                           input logic [3:0] mask,
                                           input logic       wrap);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && mask[idx] && (i < 4 || wrap)) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign any_en    = |en_mask;
  assign xfer      = (state == SEND) && out_ready[sel];
  // Held low during reset; otherwise a slot is free when idle or when the
  // held word leaves this cycle, giving one word per cycle.
  assign in_ready  = rst_n && any_en && ((state == IDLE) || xfer);
  assign accept    = in_valid && in_ready;
  assign timed_out = (TIMEOUT > 0) && (state == SEND) && !xfer && (cnt == TO_LAST);

  // Next-state logic: accept, transfer, timeout re-target and stall counting.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    sel_n   = sel;
    last_n  = last_lane;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    if (xfer) last_n = sel;
    if (accept) begin
      hold_n  = in_data;
      sel_n   = next_lane((state == SEND) ? sel : last_lane, en_mask, 1'b1);
      state_n = SEND;
      cnt_n   = '0;
    end else if (xfer) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == SEND) begin
      if (timed_out) begin
        sel_n   = next_lane(sel, en_mask, 1'b0);
        cnt_n   = '0;
        pulse_n = 1'b1;
      end else if (TIMEOUT > 0) begin
        cnt_n = cnt + TO_W'(1);
      end
    end
  end

  // State register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      sel       <= 2'd0;
      last_lane <= 2'd3;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      sel       <= sel_n;
      last_lane <= last_n;
      cnt       <= cnt_n;
      pulse     <= pulse_n;
    end
  end

  // Outputs decode registered state only; unselected lanes drive zero.
  always_comb begin
    out_valid = 4'b0000;
    out_a     = '0;
    out_b     = '0;
    out_c     = '0;
    out_d     = '0;
    if (state == SEND) begin
      out_valid = 4'b0001 << sel;
      case (sel)
        2'd0:    out_a = hold;
        2'd1:    out_b = hold;
        2'd2:    out_c = hold;
        default: out_d = hold;
      endcase
    end
  end

  assign timeout_pulse = pulse;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher (TIMEOUT=4).
module tb_demux_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] en_mask;
  logic [3:0] out_ready;
  logic [3:0] out_valid;
  logic [1:0] sel;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] words[5];
  int         lanes[5];

  demux_rr_dispatcher #(.N(8), .TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en_mask(en_mask), .out_ready(out_ready),
    .out_valid(out_valid), .sel(sel), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_d(out_d), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_lanes(input int lane, input logic [7:0] d);
    logic [3:0] ev;
    ev = 4'b0001 << lane;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("sel", 32'(sel), lane);
    chk("out_a", 32'(out_a), (lane == 0) ? 32'(d) : 0);
    chk("out_b", 32'(out_b), (lane == 1) ? 32'(d) : 0);
    chk("out_c", 32'(out_c), (lane == 2) ? 32'(d) : 0);
    chk("out_d", 32'(out_d), (lane == 3) ? 32'(d) : 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_pulse", 32'(timeout_pulse), 0);
    rst_n = 1'b1;
  endtask

  // Back-to-back stream of n words from words[], expecting lanes[].
  task automatic stream(input int n);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 1);
      if (i == 0) chk("first_gap", 32'(out_valid), 0);
      else check_lanes(lanes[i-1], words[i-1]);
      @(posedge clk); #1;
      if (i < n - 1) in_data = words[i+1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check_lanes(lanes[n-1], words[n-1]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_vld", 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data   = 8'h00;
    in_valid  = 1'b0;
    en_mask   = 4'hF;
    out_ready = 4'hF;
    do_reset();

    // Round robin over all lanes.
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    lanes = '{0, 1, 2, 3, 0};
    stream(5);

    // Masked lanes skipped: last lane was a, so b, d, b.
    en_mask = 4'b1010;
    words = '{8'h61, 8'h62, 8'h63, 8'h00, 8'h00};
    lanes = '{1, 3, 1, 0, 0};
    stream(3);

    // Timeout re-target from a to b.
    do_reset();
    en_mask   = 4'hF;
    out_ready = 4'b1110;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    chk("t3_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("t3_vld", 32'(out_valid), 32'h1);
      chk("t3_out_a", 32'(out_a), 32'hA5);
      chk("t3_pulse", 32'(timeout_pulse), 0);
      chk("t3_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t3_pulse_hi", 32'(timeout_pulse), 1);
    check_lanes(1, 8'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_done_vld", 32'(out_valid), 0);
    chk("t3_pulse_lo", 32'(timeout_pulse), 0);

    // Single enabled lane, stalled: repeated pulses, sel stays a.
    en_mask   = 4'b0001;
    out_ready = 4'b0000;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    chk("t4_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("t4_pulse", 32'(timeout_pulse), (j % 4 == 1 && j > 1) ? 1 : 0);
      chk("t4_sel", 32'(sel), 0);
      chk("t4_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 4'b0001;
    @(negedge clk);
    chk("t4_out_a", 32'(out_a), 32'h3C);
    chk("t4_in_ready_xfer", 32'(in_ready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_done_vld", 32'(out_valid), 0);

    // No lanes enabled: stall, then enable c.
    en_mask   = 4'b0000;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    in_data   = 8'h7E;
    repeat (5) begin
      @(negedge clk);
      chk("t5_in_ready", 32'(in_ready), 0);
      chk("t5_vld", 32'(out_valid), 0);
    end
    @(negedge clk);
    en_mask = 4'b0100;
    #1;
    chk("t5_in_ready_en", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_lanes(2, 8'h7E);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_done_vld", 32'(out_valid), 0);

    // Reset mid-send clears outputs at once; next word goes to a.
    en_mask   = 4'hF;
    out_ready = 4'b0000;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_lanes(3, 8'h99);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_vld", 32'(out_valid), 0);
    chk("t6_out_d", 32'(out_d), 0);
    chk("t6_in_ready", 32'(in_ready), 0);
    chk("t6_sel", 32'(sel), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 4'hF;
    words = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
    lanes = '{0, 0, 0, 0, 0};
    stream(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
